apb_master: RTL and testbench
=============================

// Module: apb_master
// PURPOSE
//  APB requester: converts single-beat commands from a local valid/ready port into APB
//  SETUP/ACCESS transfers toward an APB completer such as the team's apb_slave.
//  Returns read data or write completion on a one-cycle response strobe.
//  Sits between the testbench/bus-bridge side and the APB fabric; one transfer in flight.
// PARAMETERS
//  ADDR_W          32  APB address width (paddr, cmd_addr)
//  DATA_W          32  APB data width (pwdata, prdata, cmd_wdata, rsp_rdata)
//  TIMEOUT_CYCLES  16  max ACCESS cycles waiting for pready (used only with APB_TIMEOUT_EN)
// PORTS
//  pclk       in   1       clock, all logic on rising edge
//  prst       in   1       reset, asynchronous, active-high
//  cmd_valid  in   1       command request
//  cmd_ready  out  1       command accepted when cmd_valid & cmd_ready
//  cmd_write  in   1       1=write, 0=read
//  cmd_addr   in   ADDR_W  transfer address
//  cmd_wdata  in   DATA_W  write data
//  rsp_valid  out  1       one-cycle completion strobe
//  rsp_rdata  out  DATA_W  read data (valid with rsp_valid on reads; 0 on writes)
//  rsp_err    out  1       timeout abort flag (valid with rsp_valid; 0 without APB_TIMEOUT_EN)
//  psel       out  1       APB select
//  pen        out  1       APB enable
//  pwrite     out  1       APB direction
//  paddr      out  ADDR_W  APB address
//  pwdata     out  DATA_W  APB write data
//  prdata     in   DATA_W  APB read data from completer
//  pready     in   1       APB ready from completer
// BEHAVIOUR
//  - Reset: one clock pclk; reset prst asynchronous, active-high. On prst all outputs 0,
//    state IDLE, timeout counter 0. Reset mid-transfer drops psel/pen at once; no rsp_valid.
//  - FSM IDLE -> SETUP -> ACCESS -> IDLE.
//    IDLE:   cmd_ready=1; on cmd_valid register cmd_write/addr/wdata into pwrite/paddr/pwdata,
//            go SETUP. psel=0, pen=0.
//    SETUP:  psel=1, pen=0, exactly one cycle; -> ACCESS.
//    ACCESS: psel=1, pen=1; hold paddr/pwrite/pwdata stable; stay while pready=0.
//            On edge with pready=1: capture prdata into rsp_rdata (reads), pulse rsp_valid
//            next cycle, psel=pen=0, -> IDLE.
//  - cmd_ready=1 only in IDLE; cmd_valid outside IDLE ignored (no queuing).
//  - Latency: accept at edge N -> SETUP in cycle N+1, ACCESS N+2; pready=1 in ACCESS cycle
//    N+2+k -> rsp_valid in cycle N+3+k. Minimum accept-to-accept interval 4 cycles.
//  - rsp_rdata holds last read value until next read completes; writes force rsp_rdata=0
//    during their rsp_valid cycle only.
//  - pready/prdata ignored outside ACCESS.
//  - paddr/pwdata/pwrite retain last transfer values in IDLE (no toggling).
// CONFIGURATION
//  - APB_TIMEOUT_EN defined: counter cleared on SETUP, increments each ACCESS cycle with
//    pready=0; when it reaches TIMEOUT_CYCLES, abort: -> IDLE, rsp_valid=1, rsp_err=1,
//    rsp_rdata=0. pready=1 in the same cycle as the limit wins (normal completion, rsp_err=0).
//  - Undefined: no counter; ACCESS waits indefinitely; rsp_err tied 0.
// STRUCTURE
//  - apb_pkg: typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e; cmd struct
//    (write, addr, wdata); APB_ADDR_W/APB_DATA_W defaults shared with apb_slave.
//  - Sub-module apb_timeout_ctr (clear, inc, limit -> expired), instantiated only under
//    APB_TIMEOUT_EN. Everything else single always_ff FSM + output regs.
// TESTING
//  1 Write, pready=1 immediately: addr 0x4, data 0xDEAD_BEEF -> psel high 2 cycles, pen 1 cycle,
//    pwrite=1, rsp_valid 1 cycle, rsp_err=0; apb_slave mem[4]=0xDEAD_BEEF.
//  2 Read back addr 0x4 -> rsp_rdata=0xDEAD_BEEF on rsp_valid, pwrite=0 throughout.
//  3 Wait states: pready held 0 for 3 ACCESS cycles -> paddr/pwdata stable, rsp_valid exactly
//    4 cycles after SETUP ends; cmd_valid pulsed meanwhile is not accepted (cmd_ready=0).
//  4 Back-to-back: cmd_valid held with 3 writes (0x0,0x8,0xC) -> 3 rsp_valid pulses, accepts 4 cycles apart.
//  5 prst asserted mid-ACCESS -> psel/pen/rsp_valid 0 same cycle, IDLE, cmd_ready=1 after release.
//  6 APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready stuck 0 -> rsp_valid with rsp_err=1 after 16
//    ACCESS cycles; repeat with pready=1 on cycle 16 -> rsp_err=0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM states, command record and default bus widths,
// common to apb_master and apb_slave.
package apb_pkg;

    localparam int APB_ADDR_W         = 32;
    localparam int APB_DATA_W         = 32;
    localparam int APB_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

    // Counter width able to hold the value 'limit' itself.
    function automatic int ctr_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/apb_timeout_ctr.sv
// ACCESS-phase wait counter: cleared at SETUP, counts stalled ACCESS cycles and
// flags the stalled cycle that brings the count up to 'limit'.
module apb_timeout_ctr #(
    parameter int W = 5
) (
    input  logic         pclk,
    input  logic         prst,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != limit)) begin
            count <= count + 1'b1;
        end
    end

    // Expiry is decided in the stalled cycle itself so the abort lands on the same edge.
    assign expired = inc && (count == limit - 1'b1);

endmodule

// File: rtl/apb_master.sv
// APB requester: one valid/ready command at a time turned into a SETUP/ACCESS transfer.
// Optional macro APB_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYCLES stalled cycles.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              pen,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    apb_state_e        state;
    logic [DATA_W-1:0] rd_hold;
    logic              timeout_hit;

`ifdef APB_TIMEOUT_EN
    localparam int CW = ctr_width(TIMEOUT_CYCLES);

    apb_timeout_ctr #(
        .W (CW)
    ) u_timeout (
        .pclk    (pclk),
        .prst    (prst),
        .clear   (state == SETUP),
        .inc     ((state == ACCESS) && !pready),
        .limit   (CW'(TIMEOUT_CYCLES)),
        .expired (timeout_hit)
    );
`else
    localparam int timeout_unused = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    // cmd_ready rises one cycle after entering IDLE, giving the 4-cycle accept interval.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            psel      <= 1'b0;
            pen       <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rd_hold   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    rsp_rdata <= rd_hold;
                    if (cmd_ready && cmd_valid) begin
                        pwrite    <= cmd_write;
                        paddr     <= cmd_addr;
                        pwdata    <= cmd_wdata;
                        psel      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= SETUP;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    pen   <= 1'b1;
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel      <= 1'b0;
                        pen       <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= IDLE;
                        if (pwrite) begin
                            rsp_rdata <= '0;
                        end else begin
                            rsp_rdata <= prdata;
                            rd_hold   <= prdata;
                        end
                    end else if (timeout_hit) begin
                        psel      <= 1'b0;
                        pen       <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed scoreboard bench for apb_master with a behavioural APB completer.
// Timeout steps run only when APB_TIMEOUT_EN is defined.
module tb_apb_master;
    import apb_pkg::*;

    logic        pclk      = 1'b0;
    logic        prst      = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr  = '0;
    logic [31:0] cmd_wdata = '0;
    logic [31:0] prdata    = '0;
    logic        pready    = 1'b0;
    logic        cmd_ready, rsp_valid, rsp_err, psel, pen, pwrite;
    logic [31:0] rsp_rdata, paddr, pwdata;

    apb_master dut (
        .pclk      (pclk),
        .prst      (prst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .pen       (pen),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [16];
    logic [31:0] comp_mem  [16];
    logic [31:0] last_read   = '0;
    int          wait_states = 0;
    int          acc_cnt     = 0;
    int          tests       = 0;
    int          fails       = 0;
    int          cyc         = 0;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
        cyc++;
    endtask

    // Completer: stalls wait_states ACCESS cycles, then answers from comp_mem.
    always begin
        @(posedge pclk);
        if (psel && pen && pready && pwrite) comp_mem[paddr[5:2]] = pwdata;
        #1;
        if (psel && pen) begin
            pready = (acc_cnt >= wait_states);
            acc_cnt++;
        end else begin
            pready  = 1'b0;
            acc_cnt = 0;
        end
        prdata = pready ? comp_mem[paddr[5:2]] : 32'hBAD0_5A5A;
    end

    // Response monitor: every rsp_valid cycle consumes one scoreboard entry.
    always begin
        exp_t e;
        @(posedge pclk);
        #1;
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("[TB] FAIL rsp_unexpected: observed rsp_valid 1 expected no pending response");
            end else begin
                e = sb.pop_front();
                check_output("rsp_rdata", rsp_rdata, e.rdata);
                check_output("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    task automatic wait_ready(input string tag);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_output(tag, 32'(cmd_ready), 32'd1);
    endtask

    // One transfer with full phase checking; access_len <= waits means a timeout abort.
    task automatic apply_stimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                  input int waits, input int access_len, input bit pulse);
        exp_t e;
        wait_states = waits;
        cmd_write   = w;
        cmd_addr    = a;
        cmd_wdata   = d;
        cmd_valid   = 1'b1;
        wait_ready("accept_ready");
        e.err   = (access_len <= waits);
        e.rdata = (e.err || w) ? 32'h0 : model_mem[a[5:2]];
        if (w && !e.err) model_mem[a[5:2]] = d;
        if (!w && !e.err) last_read = e.rdata;
        sb.push_back(e);
        tick();
        cmd_valid = 1'b0;
        check_output("setup_psel", 32'(psel), 32'd1);
        check_output("setup_pen", 32'(pen), 32'd0);
        check_output("setup_pwrite", 32'(pwrite), 32'(w));
        check_output("setup_paddr", paddr, a);
        check_output("setup_pwdata", pwdata, d);
        for (int i = 0; i < access_len; i++) begin
            tick();
            if (pulse) begin
                cmd_valid = (i == 0);
                cmd_addr  = 32'h3C;
            end
            check_output("access_psel", 32'(psel), 32'd1);
            check_output("access_pen", 32'(pen), 32'd1);
            check_output("access_pwrite", 32'(pwrite), 32'(w));
            check_output("access_paddr", paddr, a);
            check_output("access_pwdata", pwdata, d);
            check_output("access_cmd_ready", 32'(cmd_ready), 32'd0);
            check_output("access_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        cmd_valid = 1'b0;
        tick();
        check_output("rsp_valid_rise", 32'(rsp_valid), 32'd1);
        check_output("rsp_psel_low", 32'(psel), 32'd0);
        check_output("rsp_pen_low", 32'(pen), 32'd0);
        tick();
        check_output("rsp_valid_pulse", 32'(rsp_valid), 32'd0);
        check_output("idle_rdata_hold", rsp_rdata, last_read);
        check_output("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        check_output("idle_paddr_kept", paddr, a);
    endtask

    initial begin
        apb_cmd_t cmds[3];
        int       acc_cyc[3];
        exp_t     e;

        for (int i = 0; i < 16; i++) begin
            model_mem[i] = 32'h1111_1111 * i;
            comp_mem[i]  = 32'h1111_1111 * i;
        end

        tick();
        tick();
        check_output("reset_psel", 32'(psel), 32'd0);
        check_output("reset_pen", 32'(pen), 32'd0);
        check_output("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        check_output("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("reset_rsp_err", 32'(rsp_err), 32'd0);
        check_output("reset_paddr", paddr, 32'h0);
        check_output("reset_pwdata", pwdata, 32'h0);
        check_output("reset_rsp_rdata", rsp_rdata, 32'h0);
        prst = 1'b0;
        tick();
        check_output("post_reset_ready", 32'(cmd_ready), 32'd1);

        apply_stimulus(1'b1, 32'h4, 32'hDEAD_BEEF, 0, 1, 1'b0);
        check_output("comp_mem4", comp_mem[1], 32'hDEAD_BEEF);
        apply_stimulus(1'b0, 32'h4, 32'h0, 0, 1, 1'b0);
        apply_stimulus(1'b1, 32'h10, 32'hCAFE_0010, 3, 4, 1'b1);
        apply_stimulus(1'b0, 32'h10, 32'h0, 3, 4, 1'b0);

        cmds[0] = '{write: 1'b1, addr: 32'h0, wdata: 32'hA5A5_0000};
        cmds[1] = '{write: 1'b1, addr: 32'h8, wdata: 32'hA5A5_0008};
        cmds[2] = '{write: 1'b1, addr: 32'hC, wdata: 32'hA5A5_000C};
        wait_states = 0;
        cmd_valid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_write = cmds[i].write;
            cmd_addr  = cmds[i].addr;
            cmd_wdata = cmds[i].wdata;
            wait_ready("b2b_ready");
            acc_cyc[i] = cyc;
            model_mem[cmds[i].addr[5:2]] = cmds[i].wdata;
            e.rdata = 32'h0;
            e.err   = 1'b0;
            sb.push_back(e);
            tick();
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_output("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
        check_output("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
        check_output("b2b_mem8", comp_mem[2], 32'hA5A5_0008);
        apply_stimulus(1'b0, 32'hC, 32'h0, 1, 2, 1'b0);

        wait_states = 100;
        cmd_write   = 1'b0;
        cmd_addr    = 32'h4;
        cmd_valid   = 1'b1;
        wait_ready("rst_accept");
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check_output("pre_rst_pen", 32'(pen), 32'd1);
        prst = 1'b1;
        #1;
        check_output("rst_psel", 32'(psel), 32'd0);
        check_output("rst_pen", 32'(pen), 32'd0);
        check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("rst_rsp_rdata", rsp_rdata, 32'h0);
        last_read = 32'h0;
        tick();
        tick();
        prst = 1'b0;
        tick();
        check_output("rst_release_ready", 32'(cmd_ready), 32'd1);
        apply_stimulus(1'b0, 32'h4, 32'h0, 1, 2, 1'b0);

`ifdef APB_TIMEOUT_EN
        apply_stimulus(1'b0, 32'h8, 32'h0, 1000, 16, 1'b0);
        apply_stimulus(1'b0, 32'h8, 32'h0, 15, 16, 1'b0);
`endif

        tick();
        check_output("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
